// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed BCD display scanner: one digit per slot with a blanking gap, tear-free
// value updates committed only at frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  input  logic                    lz_en_i,
  output logic [3:0]              digit_o,
  output logic                    blank_o,
  output logic [NUM_DIGITS-1:0]   dig_en_o,
  output logic                    frame_o
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned ValW = 4 * NUM_DIGITS;

  localparam logic [CntW-1:0] CntMax     = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] BlankLimit = CntW'(BLANK_CYCLES);
  localparam logic [IdxW-1:0] IdxMax     = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [ValW-1:0]       active_q, active_d;
  logic [ValW-1:0]       shadow_q, shadow_d;
  logic                  pending_q, pending_d;

  logic [3:0]            digit_q, digit_d;
  logic                  blank_q, blank_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  frame_q, frame_d;

  logic                  slot_end;
  logic                  boundary;
  logic                  accept;
  logic                  show;
  logic                  upper_nz;
  logic [3:0]            nib;

  always_comb begin
    slot_end  = (cnt_q == CntMax);
    boundary  = slot_end && (idx_q == IdxMax);
    accept    = load_valid_i && !pending_q;

    cnt_d     = slot_end ? '0 : cnt_q + CntW'(1);
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
    end

    active_d  = (boundary && pending_q) ? shadow_q : active_q;
    shadow_d  = accept ? bcd_i : shadow_q;
    pending_d = pending_q;
    if (accept) begin
      pending_d = 1'b1;
    end else if (boundary) begin
      pending_d = 1'b0;
    end
  end

  // Outputs are computed from next-state so the registered values line up with cnt/idx.
  always_comb begin
    nib      = active_d[{idx_d, 2'b00} +: 4];
    show     = (cnt_d >= BlankLimit);
    upper_nz = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (k >= int'(idx_d) && active_d[4*k +: 4] != 4'd0) begin
        upper_nz = 1'b1;
      end
    end

    digit_d  = nib;
    dig_en_d = show ? (NUM_DIGITS'(1) << idx_d) : '0;
    blank_d  = !show || (nib > 4'd9) || (lz_en_i && (idx_d != '0) && !upper_nz);
    frame_d  = boundary;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      digit_q   <= 4'd0;
      blank_q   <= 1'b1;
      dig_en_q  <= '0;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      digit_q   <= digit_d;
      blank_q   <= blank_d;
      dig_en_q  <= dig_en_d;
      frame_q   <= frame_d;
    end
  end

  assign load_ready_o = ~pending_q;
  assign digit_o      = digit_q;
  assign blank_o      = blank_q;
  assign dig_en_o     = dig_en_q;
  assign frame_o      = frame_q;

endmodule
